// File: rtl/token_ring_pkg.sv
// Shared FSM state encoding and default sizing for the sample arbiter.
package token_ring_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    RESP,
    RELEASE
  } state_t;

  localparam int unsigned DEF_STAGES     = 5;
  localparam int unsigned DEF_DETECT_LAT = 2;

endpackage

// File: rtl/sample_sync.sv
// Per-bit multi-flop synchronizer for asynchronous request lines, cleared by rst.
module sample_sync #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] chain [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) chain[i] <= '0;
    end else begin
      chain[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) chain[i] <= chain[i-1];
    end
  end

  assign dout = chain[DEPTH-1];

endmodule

// File: rtl/sample_arbiter.sv
// Round-robin four-phase arbiter answering ring-stage samples with Err0/Err1.
// Optional statistics counters are enabled with `define SAMPLE_ARB_STATS_EN.
module sample_arbiter
  import token_ring_pkg::*;
#(
  parameter  int unsigned STAGES      = DEF_STAGES,
  parameter  int unsigned DETECT_LAT  = DEF_DETECT_LAT,
  parameter  int unsigned SYNC_STAGES = 2,
  localparam int unsigned IDX_W       = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] sample,
  input  logic [STAGES-1:0] inj_mask,
  output logic [STAGES-1:0] Err0,
  output logic [STAGES-1:0] Err1,
  output logic              busy,
  output logic [IDX_W-1:0]  grant_idx
`ifdef SAMPLE_ARB_STATS_EN
  ,
  output logic [15:0]       err_count,
  output logic [15:0]       grant_count
`endif
);

  state_t            state, state_n;
  logic [STAGES-1:0] sync_sample;
  logic [3:0]        cnt, cnt_n;
  logic [IDX_W-1:0]  rr_ptr, rr_n;
  logic [IDX_W-1:0]  grant_n;
  logic              mask_lat, mask_n;
  logic [STAGES-1:0] err0_n, err1_n;
  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;

  sample_sync #(
    .WIDTH (STAGES),
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sample),
    .dout (sync_sample)
  );

  // First pending stage at or after rr_ptr, wrapping without a modulo operator.
  always_comb begin
    int unsigned cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      cand = 32'(rr_ptr) + i;
      if (cand >= STAGES) cand = cand - STAGES;
      if (!pick_found && sync_sample[IDX_W'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rr_n    = rr_ptr;
    grant_n = grant_idx;
    mask_n  = mask_lat;
    err0_n  = Err0;
    err1_n  = Err1;
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          grant_n = pick_idx;
          mask_n  = inj_mask[pick_idx];
          cnt_n   = '0;
          state_n = EVAL;
        end
      end
      EVAL: begin
        if (!sync_sample[grant_idx]) begin
          state_n = RELEASE;
        end else if (cnt == 4'(DETECT_LAT - 1)) begin
          state_n = RESP;
          if (mask_lat) err1_n[grant_idx] = 1'b1;
          else          err0_n[grant_idx] = 1'b1;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      RESP: begin
        if (!sync_sample[grant_idx]) begin
          state_n = RELEASE;
          err0_n  = '0;
          err1_n  = '0;
        end
      end
      RELEASE: begin
        err0_n  = '0;
        err1_n  = '0;
        rr_n    = (grant_idx == IDX_W'(STAGES - 1)) ? '0 : grant_idx + IDX_W'(1);
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rr_ptr    <= '0;
      grant_idx <= '0;
      mask_lat  <= 1'b0;
      Err0      <= '0;
      Err1      <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rr_ptr    <= rr_n;
      grant_idx <= grant_n;
      mask_lat  <= mask_n;
      Err0      <= err0_n;
      Err1      <= err1_n;
    end
  end

  assign busy = (state != IDLE);

`ifdef SAMPLE_ARB_STATS_EN
  logic grant_fire, err_fire;

  assign grant_fire = (state == IDLE) && pick_found;
  assign err_fire   = (state == EVAL) && (state_n == RESP) && mask_lat;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count   <= '0;
      grant_count <= '0;
    end else begin
      if (grant_fire && grant_count != '1) grant_count <= grant_count + 16'd1;
      if (err_fire && err_count != '1)     err_count   <= err_count + 16'd1;
    end
  end
`endif

endmodule
